// File: rtl/parametrik_veri_onbellegi.sv
`default_nettype none
// ============================================================================
// parametrik_veri_onbellegi : direct-mapped, write-back, write-allocate data
// cache. Optional hit/miss counters: `define PARAMETRIK_VERI_ONBELLEGI_SAYAC_EN
// Revision 1.0
// ============================================================================
module parametrik_veri_onbellegi #(
    parameter int SATIR_SAYISI = 512,
    parameter int ADR_BIT      = 19
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        bib_sec_n_i,
    input  logic        bib_yaz_i,
    input  logic [31:0] bib_adr_i,
    input  logic [31:0] bib_veri_i,
    input  logic [3:0]  bib_maske_i,
    output logic [31:0] bib_veri_o,
    output logic        bib_durdur_o,
    input  logic        temizle_i,
    output logic        temizle_bitti_o,
    output logic [31:0] ab_adr_o,
    output logic        ab_gecerli_o,
    output logic        ab_yaz_o,
    output logic [31:0] ab_veri_o,
    input  logic [31:0] ab_veri_i,
    input  logic        ab_hazir_i
`ifdef PARAMETRIK_VERI_ONBELLEGI_SAYAC_EN
    ,
    output logic [31:0] isabet_sayisi_o,
    output logic [31:0] iska_sayisi_o
`endif
);

    localparam int IDX_W = $clog2(SATIR_SAYISI);
    localparam int TAG_W = ADR_BIT - 2 - IDX_W;
    localparam logic [IDX_W-1:0] C_SON_IDX = IDX_W'(SATIR_SAYISI - 1);
    // Shift by 32 yields 0, so the mask degenerates to all word bits for ADR_BIT=32
    localparam logic [31:0] C_ADR_MASKE = ((32'd1 << ADR_BIT) - 32'd1) & 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        BEKLE    = 3'd0,
        GERI_YAZ = 3'd1,
        DOLDUR   = 3'd2,
        TAMAM    = 3'd3,
        TEMIZLE  = 3'd4
    } durum_t;

    durum_t             r_durum;
    logic [31:0]        r_veri   [SATIR_SAYISI];
    logic [TAG_W-1:0]   r_etiket [SATIR_SAYISI];
    logic [SATIR_SAYISI-1:0] r_gecerli;
    logic [SATIR_SAYISI-1:0] r_kirli;
    logic               r_temizle_bekle;
    logic [IDX_W-1:0]   r_sayac;
    logic               r_temizle_bitti;
    logic               r_ab_gecerli;
    logic               r_ab_yaz;
    logic [31:0]        r_ab_adr;
    logic [31:0]        r_ab_veri;

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_etiket;
    logic [31:0]        w_istek_adr;
    logic               w_istek;
    logic               w_temizle_ist;
    logic               w_isabet;
    logic               w_bekle_isabet;
    logic               w_doldur_bitti;
    logic               w_hat_yaz_en;
    logic [31:0]        w_hat_yeni;
    logic               w_durdur;

    function automatic logic [31:0] birlestir(input logic [31:0] eski,
                                              input logic [31:0] yeni,
                                              input logic [3:0]  maske);
        logic [31:0] s;
        s = eski;
        for (int b = 0; b < 4; b++) begin
            if (maske[b]) s[8*b +: 8] = yeni[8*b +: 8];
        end
        return s;
    endfunction

    function automatic logic [31:0] hat_adresi(input logic [TAG_W-1:0] etiket,
                                               input logic [IDX_W-1:0] idx);
        return 32'({etiket, idx, 2'b00});
    endfunction

    assign w_idx          = bib_adr_i[IDX_W+1:2];
    assign w_etiket       = bib_adr_i[ADR_BIT-1:IDX_W+2];
    assign w_istek_adr    = bib_adr_i & C_ADR_MASKE;
    assign w_istek        = ~bib_sec_n_i;
    assign w_temizle_ist  = temizle_i | r_temizle_bekle;
    assign w_isabet       = r_gecerli[w_idx] && (r_etiket[w_idx] == w_etiket);
    assign w_bekle_isabet = (r_durum == BEKLE) && w_istek && !w_temizle_ist && w_isabet;
    assign w_doldur_bitti = (r_durum == DOLDUR) && r_ab_gecerli && ab_hazir_i;
    assign w_hat_yaz_en   = (w_bekle_isabet && bib_yaz_i) || w_doldur_bitti;

    always_comb begin
        w_hat_yeni = birlestir(r_veri[w_idx], bib_veri_i, bib_maske_i);
        if (w_doldur_bitti) begin
            w_hat_yeni = bib_yaz_i ? birlestir(ab_veri_i, bib_veri_i, bib_maske_i) : ab_veri_i;
        end
    end

    always_comb begin
        w_durdur = 1'b0;
        case (r_durum)
            BEKLE:                     w_durdur = w_temizle_ist || (w_istek && !w_isabet);
            GERI_YAZ, DOLDUR, TEMIZLE: w_durdur = 1'b1;
            default:                   w_durdur = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_durum         <= BEKLE;
            r_gecerli       <= '0;
            r_kirli         <= '0;
            r_temizle_bekle <= 1'b0;
            r_sayac         <= '0;
            r_temizle_bitti <= 1'b0;
            r_ab_gecerli    <= 1'b0;
            r_ab_yaz        <= 1'b0;
            r_ab_adr        <= '0;
            r_ab_veri       <= '0;
        end else begin
            r_temizle_bitti <= 1'b0;
            if (temizle_i && (r_durum != BEKLE)) r_temizle_bekle <= 1'b1;

            case (r_durum)
                BEKLE: begin
                    if (w_temizle_ist) begin
                        r_temizle_bekle <= 1'b0;
                        r_sayac         <= '0;
                        r_durum         <= TEMIZLE;
                    end else if (w_istek) begin
                        if (w_isabet) begin
                            if (bib_yaz_i) r_kirli[w_idx] <= 1'b1;
                        end else if (r_gecerli[w_idx] && r_kirli[w_idx]) begin
                            r_ab_gecerli <= 1'b1;
                            r_ab_yaz     <= 1'b1;
                            r_ab_adr     <= hat_adresi(r_etiket[w_idx], w_idx);
                            r_ab_veri    <= r_veri[w_idx];
                            r_durum      <= GERI_YAZ;
                        end else begin
                            r_ab_gecerli <= 1'b1;
                            r_ab_yaz     <= 1'b0;
                            r_ab_adr     <= w_istek_adr;
                            r_durum      <= DOLDUR;
                        end
                    end
                end
                GERI_YAZ: begin
                    if (ab_hazir_i) begin
                        r_ab_yaz <= 1'b0;
                        r_ab_adr <= w_istek_adr;
                        r_durum  <= DOLDUR;
                    end
                end
                DOLDUR: begin
                    if (ab_hazir_i) begin
                        r_ab_gecerli     <= 1'b0;
                        r_gecerli[w_idx] <= 1'b1;
                        r_kirli[w_idx]   <= bib_yaz_i;
                        r_durum          <= TAMAM;
                    end
                end
                TAMAM: r_durum <= BEKLE;
                TEMIZLE: begin
                    // A dirty line is written back, marked clean, then revisited as clean
                    if (r_ab_gecerli) begin
                        if (ab_hazir_i) begin
                            r_ab_gecerli     <= 1'b0;
                            r_ab_yaz         <= 1'b0;
                            r_kirli[r_sayac] <= 1'b0;
                        end
                    end else if (r_gecerli[r_sayac] && r_kirli[r_sayac]) begin
                        r_ab_gecerli <= 1'b1;
                        r_ab_yaz     <= 1'b1;
                        r_ab_adr     <= hat_adresi(r_etiket[r_sayac], r_sayac);
                        r_ab_veri    <= r_veri[r_sayac];
                    end else if (r_sayac == C_SON_IDX) begin
                        r_gecerli       <= '0;
                        r_kirli         <= '0;
                        r_sayac         <= '0;
                        r_temizle_bitti <= 1'b1;
                        r_durum         <= BEKLE;
                    end else begin
                        r_sayac <= r_sayac + 1'b1;
                    end
                end
                default: r_durum <= BEKLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_hat_yaz_en)   r_veri[w_idx]   <= w_hat_yeni;
        if (w_doldur_bitti) r_etiket[w_idx] <= w_etiket;
    end

`ifdef PARAMETRIK_VERI_ONBELLEGI_SAYAC_EN
    logic [31:0] r_isabet_sayisi;
    logic [31:0] r_iska_sayisi;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_isabet_sayisi <= '0;
            r_iska_sayisi   <= '0;
        end else begin
            if (w_bekle_isabet)    r_isabet_sayisi <= r_isabet_sayisi + 32'd1;
            if (r_durum == TAMAM)  r_iska_sayisi   <= r_iska_sayisi + 32'd1;
        end
    end

    assign isabet_sayisi_o = r_isabet_sayisi;
    assign iska_sayisi_o   = r_iska_sayisi;
`endif

    assign bib_veri_o      = r_veri[w_idx];
    assign bib_durdur_o    = w_durdur;
    assign temizle_bitti_o = r_temizle_bitti;
    assign ab_gecerli_o    = r_ab_gecerli;
    assign ab_yaz_o        = r_ab_yaz;
    assign ab_adr_o        = r_ab_adr;
    assign ab_veri_o       = r_ab_veri;

endmodule
`default_nettype wire

// File: tb/tb_parametrik_veri_onbellegi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_parametrik_veri_onbellegi : scoreboard bench with memory responder.
// Revision 1.0
// ============================================================================
module tb_parametrik_veri_onbellegi;

    localparam int N = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        bib_sec_n_i = 1'b1;
    logic        bib_yaz_i = 1'b0;
    logic [31:0] bib_adr_i = '0;
    logic [31:0] bib_veri_i = '0;
    logic [3:0]  bib_maske_i = '0;
    logic [31:0] bib_veri_o;
    logic        bib_durdur_o;
    logic        temizle_i = 1'b0;
    logic        temizle_bitti_o;
    logic [31:0] ab_adr_o;
    logic        ab_gecerli_o;
    logic        ab_yaz_o;
    logic [31:0] ab_veri_o;
    logic [31:0] ab_veri_i = '0;
    logic        ab_hazir_i = 1'b0;

    parametrik_veri_onbellegi #(.SATIR_SAYISI(N), .ADR_BIT(19)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .bib_sec_n_i(bib_sec_n_i), .bib_yaz_i(bib_yaz_i), .bib_adr_i(bib_adr_i),
        .bib_veri_i(bib_veri_i), .bib_maske_i(bib_maske_i), .bib_veri_o(bib_veri_o),
        .bib_durdur_o(bib_durdur_o), .temizle_i(temizle_i), .temizle_bitti_o(temizle_bitti_o),
        .ab_adr_o(ab_adr_o), .ab_gecerli_o(ab_gecerli_o), .ab_yaz_o(ab_yaz_o),
        .ab_veri_o(ab_veri_o), .ab_veri_i(ab_veri_i), .ab_hazir_i(ab_hazir_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        yaz;
        logic [31:0] adr;
        logic [31:0] veri;
        logic [31:0] donus;
        int          gecikme;
    } ab_islem_t;

    typedef struct {
        logic        kontrol_et;
        logic [31:0] veri;
        int          durdur;
    } bib_yanit_t;

    ab_islem_t  ab_kuyruk[$];
    bib_yanit_t bib_kuyruk[$];
    int total = 0;
    int bad   = 0;

    task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        total++;
        if (gercek !== beklenen) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", ad, gercek, beklenen);
        end
    endtask

    task automatic ab_bekle(input logic yaz, input logic [31:0] adr, input logic [31:0] veri,
                            input logic [31:0] donus, input int gecikme);
        ab_islem_t t;
        t.yaz = yaz; t.adr = adr; t.veri = veri; t.donus = donus; t.gecikme = gecikme;
        ab_kuyruk.push_back(t);
    endtask

    // Issue one core request and hold it until the cache stops stalling.
    task automatic istek(input logic yaz, input logic [31:0] adr, input logic [31:0] veri,
                         input logic [3:0] maske, input logic kontrol_et,
                         input logic [31:0] beklenen, input int durdur);
        bib_yanit_t y;
        int n;
        y.kontrol_et = kontrol_et; y.veri = beklenen; y.durdur = durdur;
        bib_kuyruk.push_back(y);
        @(posedge clk_i); #1;
        bib_sec_n_i = 1'b0; bib_yaz_i = yaz; bib_adr_i = adr;
        bib_veri_i = veri; bib_maske_i = maske;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (bib_durdur_o && n < 200);
        if (bib_durdur_o) begin
            total++; bad++;
            $display("FAIL bib_timeout: adr=%h still stalled after %0d cycles, required completion", adr, n);
        end
        @(posedge clk_i); #1;
        bib_sec_n_i = 1'b1;
    endtask

    initial begin : bellek
        ab_islem_t cur;
        bit yeni;
        int bekle;
        yeni = 1; bekle = 0;
        cur.yaz = 0; cur.adr = 0; cur.veri = 0; cur.donus = 0; cur.gecikme = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                yeni = 1;
                ab_hazir_i = 1'b0;
            end else if (ab_gecerli_o) begin
                if (yeni) begin
                    yeni = 0; bekle = 0;
                    if (ab_kuyruk.size() == 0) begin
                        total++; bad++;
                        $display("FAIL ab_unexpected: adr=%h yaz=%b, required no transaction", ab_adr_o, ab_yaz_o);
                        cur.yaz = ab_yaz_o; cur.adr = ab_adr_o; cur.veri = ab_veri_o;
                        cur.donus = 0; cur.gecikme = 0;
                    end else begin
                        cur = ab_kuyruk.pop_front();
                        kontrol("ab_yaz", {31'd0, ab_yaz_o}, {31'd0, cur.yaz});
                        kontrol("ab_adr", ab_adr_o, cur.adr);
                        if (cur.yaz) kontrol("ab_veri", ab_veri_o, cur.veri);
                    end
                end else begin
                    kontrol("ab_stable_adr", ab_adr_o, cur.adr);
                    kontrol("ab_stable_yaz", {31'd0, ab_yaz_o}, {31'd0, cur.yaz});
                    if (cur.yaz) kontrol("ab_stable_veri", ab_veri_o, cur.veri);
                end
                if (bekle >= cur.gecikme) begin
                    ab_veri_i  = cur.donus;
                    ab_hazir_i = 1'b1;
                    @(posedge clk_i); #1;
                    ab_hazir_i = 1'b0;
                    yeni = 1;
                end else begin
                    bekle++;
                end
            end
        end
    end

    initial begin : izleyici
        int durdur_sayisi;
        bib_yanit_t b;
        durdur_sayisi = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni || bib_sec_n_i) begin
                durdur_sayisi = 0;
            end else if (bib_durdur_o) begin
                durdur_sayisi++;
            end else begin
                if (bib_kuyruk.size() == 0) begin
                    total++; bad++;
                    $display("FAIL bib_unexpected: completion at adr=%h, required none", bib_adr_i);
                end else begin
                    b = bib_kuyruk.pop_front();
                    kontrol("bib_stall_cycles", durdur_sayisi, b.durdur);
                    if (b.kontrol_et) kontrol("bib_veri", bib_veri_o, b.veri);
                end
                durdur_sayisi = 0;
            end
        end
    end

    initial begin : bekci
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin : ana
        int  n;
        bit  goruldu;
        repeat (3) @(negedge clk_i);
        kontrol("reset_ab_gecerli", {31'd0, ab_gecerli_o}, 32'd0);
        kontrol("reset_ab_yaz", {31'd0, ab_yaz_o}, 32'd0);
        kontrol("reset_ab_adr", ab_adr_o, 32'd0);
        kontrol("reset_ab_veri", ab_veri_o, 32'd0);
        kontrol("reset_durdur", {31'd0, bib_durdur_o}, 32'd0);
        kontrol("reset_bitti", {31'd0, temizle_bitti_o}, 32'd0);
        rst_ni = 1'b1;

        // Cold read miss, then a hit on the same word
        ab_bekle(0, 32'h100, 0, 32'hDEADBEEF, 0);
        istek(0, 32'h100, 0, 4'h0, 1, 32'hDEADBEEF, 2);
        istek(0, 32'h100, 0, 4'h0, 1, 32'hDEADBEEF, 0);
        // Masked write hit, read back the merge
        istek(1, 32'h100, 32'h11223344, 4'b0011, 0, 0, 0);
        istek(0, 32'h100, 0, 4'h0, 1, 32'hDEAD3344, 0);
        // Conflict: write back victim first, then refill
        ab_bekle(1, 32'h100, 32'hDEAD3344, 0, 0);
        ab_bekle(0, 32'h100 + 4*N, 0, 32'hCAFEF00D, 0);
        istek(0, 32'h100 + 4*N, 0, 4'h0, 1, 32'hCAFEF00D, 3);
        // Slow memory: 20 extra cycles of ab_hazir_i low
        ab_bekle(0, 32'h108, 0, 32'h01234567, 20);
        istek(0, 32'h108, 0, 4'h0, 1, 32'h01234567, 22);
        // Write-allocate miss with mask merge into fetched word
        ab_bekle(0, 32'h104, 0, 32'h55667788, 0);
        istek(1, 32'h104, 32'hAABBCCDD, 4'b1100, 1, 32'hAABB7788, 2);
        istek(1, 32'h140, 32'h12345678, 4'hF, 0, 0, 0);

        // Flush with two dirty lines (index 0 and 1)
        ab_bekle(1, 32'h140, 32'h12345678, 0, 0);
        ab_bekle(1, 32'h104, 32'hAABB7788, 0, 0);
        @(posedge clk_i); #1 temizle_i = 1'b1;
        @(posedge clk_i); #1 temizle_i = 1'b0;
        n = 1; goruldu = 0;
        while (n < 200) begin
            @(negedge clk_i);
            if (temizle_bitti_o) begin
                goruldu = 1;
                break;
            end
            @(posedge clk_i);
            n++;
        end
        kontrol("flush_done_seen", {31'd0, goruldu}, 32'd1);
        kontrol("flush_cycles", n, 32'd21);
        @(negedge clk_i);
        kontrol("flush_done_pulse", {31'd0, temizle_bitti_o}, 32'd0);
        kontrol("flush_writes_consumed", ab_kuyruk.size(), 32'd0);

        // Everything invalid after flush
        ab_bekle(0, 32'h108, 0, 32'h0BADF00D, 0);
        istek(0, 32'h108, 0, 4'h0, 1, 32'h0BADF00D, 2);
        ab_bekle(0, 32'h140, 0, 32'h11111111, 0);
        istek(0, 32'h140, 0, 4'h0, 1, 32'h11111111, 2);

        // Reset in the middle of a write-back
        istek(1, 32'h140, 32'h22222222, 4'hF, 0, 0, 0);
        ab_bekle(1, 32'h140, 32'h22222222, 0, 1000);
        @(posedge clk_i); #1;
        bib_sec_n_i = 1'b0; bib_yaz_i = 1'b0; bib_adr_i = 32'h100;
        @(negedge clk_i);
        @(negedge clk_i);
        kontrol("wb_gecerli", {31'd0, ab_gecerli_o}, 32'd1);
        kontrol("wb_yaz", {31'd0, ab_yaz_o}, 32'd1);
        #2;
        rst_ni = 1'b0;
        bib_sec_n_i = 1'b1;
        #1;
        kontrol("async_reset_ab_gecerli", {31'd0, ab_gecerli_o}, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        ab_bekle(0, 32'h140, 0, 32'h33333333, 0);
        istek(0, 32'h140, 0, 4'h0, 1, 32'h33333333, 2);

        repeat (5) @(negedge clk_i);
        kontrol("ab_queue_empty", ab_kuyruk.size(), 32'd0);
        kontrol("bib_queue_empty", bib_kuyruk.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
